dmem_responder: RTL

//  Target side of the pipeline's data-memory access: accepts load/store requests

---
 rtl/dmem_pkg.sv | 8 +
 rtl/dmem_array.sv | 23 ++
 rtl/dmem_responder.sv | 99 +++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    localparam int WORD_WIDTH_DEF = 32;
    localparam int BYTES = WORD_WIDTH_DEF / 8;
    localparam int MAX_LATENCY = 15;
    localparam int CNT_W = $clog2(MAX_LATENCY);
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word RAM with synchronous byte-enabled write and combinational read
module dmem_array #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH_WORDS = 128,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [WORD_WIDTH/8-1:0] be,
    input  logic [AW-1:0]           addr,
    input  logic [WORD_WIDTH-1:0]   wdata,
    output logic [WORD_WIDTH-1:0]   rdata
);
    logic [WORD_WIDTH-1:0] mem [DEPTH_WORDS];
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WORD_WIDTH / 8; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end
    assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency load/store target with valid/ready request and response channels
import dmem_pkg::*;
module dmem_responder #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [WORD_WIDTH-1:0]   req_addr,
    input  logic [WORD_WIDTH-1:0]   req_wdata,
    input  logic [WORD_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WORD_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);
    localparam int NB = WORD_WIDTH / 8;
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [WORD_WIDTH-3:0] DEPTH_IDX = (WORD_WIDTH-2)'(DEPTH_WORDS);
    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic we_q, we_d;
    logic [WORD_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [NB-1:0] be_q, be_d;
    logic err_q, err_d;
    logic c_we, c_err, commit;
    logic [WORD_WIDTH-1:0] c_addr, c_wdata, ram_rdata;
    logic [NB-1:0] c_be;
    // With LATENCY==1 the commit edge is the accept edge, so the live request feeds the RAM
    always_comb begin
        c_we = state_q == IDLE ? req_we : we_q;
        c_addr = state_q == IDLE ? req_addr : addr_q;
        c_wdata = state_q == IDLE ? req_wdata : wdata_q;
        c_be = state_q == IDLE ? req_be : be_q;
        c_err = (c_addr[1:0] != 2'b00) || (c_addr[WORD_WIDTH-1:2] >= DEPTH_IDX);
        state_d = state_q;
        cnt_d = cnt_q;
        we_d = we_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        be_d = be_q;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d = req_we;
                addr_d = req_addr;
                wdata_d = req_wdata;
                be_d = req_be;
                cnt_d = CNT_W'(LATENCY - 1);
                state_d = LATENCY == 1 ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = RESP;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        commit = state_d == RESP && state_q != RESP;
        rdata_d = commit ? ((c_we || c_err) ? '0 : ram_rdata) : rdata_q;
        err_d = commit ? c_err : err_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            be_q <= '0;
            rdata_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            we_q <= we_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            be_q <= be_d;
            rdata_q <= rdata_d;
            err_q <= err_d;
        end
    end
    dmem_array #(.WORD_WIDTH(WORD_WIDTH), .DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk(clk),
        .we(commit && c_we && !c_err && !reset),
        .be(c_be),
        .addr(c_addr[AW+1:2]),
        .wdata(c_wdata),
        .rdata(ram_rdata)
    );
    assign req_ready = state_q == IDLE && !reset;
    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err = err_q;
endmodule
